// File: rtl/huffman_ctrl.sv
// Huffman tree-build sequencer: counts a symbol frame, then runs sort/merge
// rounds against external sort and code-split engines, guarded by a watchdog.
module huffman_ctrl #(
  parameter int WDOG_W  = 6,
  parameter int NUM_SYM = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gray_valid,
  input  logic       sort_done,
  input  logic       split_done,
  output logic       CNT_valid,
  output logic       sort_start,
  output logic [2:0] sort_num,
  output logic       merge_en,
  output logic [2:0] round,
  output logic       split_start,
  output logic       code_valid,
  output logic       err,
  output logic [6:0] sym_cnt
);

  typedef enum logic [3:0] {
    IDLE, COUNT, SORT_REQ, SORT_WAIT, MERGE, SPLIT_REQ, SPLIT_WAIT, DONE, ERR
  } state_t;

  localparam logic [WDOG_W-1:0] WDOG_MAX      = '1;
  localparam logic [WDOG_W-1:0] WDOG_ONE      = {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        SORT_NUM_INIT = 3'(NUM_SYM);

  state_t            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              cnt_valid_d, sort_start_d, merge_en_d, split_start_d;
  logic              code_valid_d, err_d;
  logic [2:0]        sort_num_d, round_d;
  logic [6:0]        sym_cnt_d;

  // Next-state logic also computes the next value of every output, so each
  // output leaves the block straight from a flop.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    state_d       = state_q;
    wdog_d        = wdog_q;
    cnt_valid_d   = 1'b0;
    sort_start_d  = 1'b0;
    merge_en_d    = 1'b0;
    split_start_d = 1'b0;
    sort_num_d    = sort_num;
    round_d       = round;
    sym_cnt_d     = sym_cnt;
    code_valid_d  = code_valid;
    err_d         = err;

    case (state_q)
      IDLE: begin
        if (gray_valid) begin
          state_d   = COUNT;
          sym_cnt_d = 7'd1;
        end
      end
      COUNT: begin
        if (gray_valid) begin
          if (sym_cnt != 7'd127) sym_cnt_d = sym_cnt + 7'd1;
        end else begin
          state_d     = SORT_REQ;
          cnt_valid_d = 1'b1;
        end
      end
      SORT_REQ: begin
        // sort_done is deliberately not looked at here: a completion seen
        // before the request has gone out cannot belong to this round.
        wdog_d       = '0;
        sort_start_d = 1'b1;
        state_d      = SORT_WAIT;
      end
      SORT_WAIT: begin
        if (sort_done) begin
          state_d    = MERGE;
          merge_en_d = 1'b1;
          round_d    = round + 3'd1;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
          if (wdog_d == WDOG_MAX) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      MERGE: begin
        if (sort_num == 3'd2) begin
          state_d = SPLIT_REQ;
        end else begin
          sort_num_d = sort_num - 3'd1;
          state_d    = SORT_REQ;
        end
      end
      SPLIT_REQ: begin
        wdog_d        = '0;
        split_start_d = 1'b1;
        state_d       = SPLIT_WAIT;
      end
      SPLIT_WAIT: begin
        if (split_done) begin
          state_d      = DONE;
          code_valid_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
          if (wdog_d == WDOG_MAX) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      DONE, ERR: ;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      CNT_valid   <= 1'b0;
      sort_start  <= 1'b0;
      merge_en    <= 1'b0;
      split_start <= 1'b0;
      sort_num    <= SORT_NUM_INIT;
      round       <= 3'd0;
      sym_cnt     <= 7'd0;
      code_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      CNT_valid   <= cnt_valid_d;
      sort_start  <= sort_start_d;
      merge_en    <= merge_en_d;
      split_start <= split_start_d;
      sort_num    <= sort_num_d;
      round       <= round_d;
      sym_cnt     <= sym_cnt_d;
      code_valid  <= code_valid_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_huffman_ctrl.sv
// Directed bench for huffman_ctrl: nominal run, watchdog, saturation/glitch,
// mid-run reset, stray inputs, and a NUM_SYM=3 instance.
module tb_huffman_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset6, reset3, gray_valid, sort_done, split_done, sel3;

  logic       s6_cnt_valid, s6_sort_start, s6_merge_en, s6_split_start;
  logic       s6_code_valid, s6_err;
  logic [2:0] s6_sort_num, s6_round;
  logic [6:0] s6_sym_cnt;
  logic       s3_cnt_valid, s3_sort_start, s3_merge_en, s3_split_start;
  logic       s3_code_valid, s3_err;
  logic [2:0] s3_sort_num, s3_round;
  logic [6:0] s3_sym_cnt;

  huffman_ctrl dut6 (
    .clk(clk), .reset(reset6), .gray_valid(gray_valid), .sort_done(sort_done),
    .split_done(split_done), .CNT_valid(s6_cnt_valid), .sort_start(s6_sort_start),
    .sort_num(s6_sort_num), .merge_en(s6_merge_en), .round(s6_round),
    .split_start(s6_split_start), .code_valid(s6_code_valid), .err(s6_err),
    .sym_cnt(s6_sym_cnt)
  );

  huffman_ctrl #(.NUM_SYM(3)) dut3 (
    .clk(clk), .reset(reset3), .gray_valid(gray_valid), .sort_done(sort_done),
    .split_done(split_done), .CNT_valid(s3_cnt_valid), .sort_start(s3_sort_start),
    .sort_num(s3_sort_num), .merge_en(s3_merge_en), .round(s3_round),
    .split_start(s3_split_start), .code_valid(s3_code_valid), .err(s3_err),
    .sym_cnt(s3_sym_cnt)
  );

  // The instance not under test is held in reset; this view follows the other.
  logic       v_cnt_valid, v_sort_start, v_merge_en, v_split_start, v_code_valid, v_err;
  logic [2:0] v_sort_num, v_round;
  logic [6:0] v_sym_cnt;
  assign v_cnt_valid   = sel3 ? s3_cnt_valid   : s6_cnt_valid;
  assign v_sort_start  = sel3 ? s3_sort_start  : s6_sort_start;
  assign v_merge_en    = sel3 ? s3_merge_en    : s6_merge_en;
  assign v_split_start = sel3 ? s3_split_start : s6_split_start;
  assign v_code_valid  = sel3 ? s3_code_valid  : s6_code_valid;
  assign v_err         = sel3 ? s3_err         : s6_err;
  assign v_sort_num    = sel3 ? s3_sort_num    : s6_sort_num;
  assign v_round       = sel3 ? s3_round       : s6_round;
  assign v_sym_cnt     = sel3 ? s3_sym_cnt     : s6_sym_cnt;

  int n_cnt = 0, n_ss = 0, n_me = 0, n_sp = 0, mutex_err = 0, stab_err = 0;
  logic [2:0] last_sn = 3'd0;

  always @(negedge clk) begin
    if ($countones({v_cnt_valid, v_sort_start, v_merge_en, v_split_start}) > 1) mutex_err++;
    if (v_cnt_valid) n_cnt++;
    if (v_sort_start) begin
      n_ss++;
      last_sn = v_sort_num;
    end
    if (v_merge_en) begin
      n_me++;
      if (v_sort_num !== last_sn) stab_err++;
    end
    if (v_split_start) n_sp++;
  end

  int checks = 0, errors = 0;
  int s_cnt, s_ss, s_me, s_sp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    s_cnt = n_cnt; s_ss = n_ss; s_me = n_me; s_sp = n_sp;
  endtask

  task automatic feed(input int n);
    gray_valid = 1'b1;
    tick_n(n);
    gray_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset6 = 1'b0;
    reset3 = 1'b0;
    tick_n(2);
    reset6 = !sel3;
    reset3 = sel3;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pulses_flags"}, {26'd0, v_cnt_valid, v_sort_start, v_merge_en,
          v_split_start, v_code_valid, v_err}, 32'd0);
    check({tag, "_sort_num"}, v_sort_num, sel3 ? 3 : 6);
    check({tag, "_round"}, v_round, 0);
    check({tag, "_sym_cnt"}, v_sym_cnt, 0);
  endtask

  task automatic wait_sort_start();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (v_sort_start) seen = 1'b1;
    end
    check("sort_start_seen", seen, 1);
  endtask

  // Answers one sort round with sort_done three cycles after sort_start.
  task automatic sort_round(input logic [2:0] exp_num);
    wait_sort_start();
    check("sort_num", v_sort_num, exp_num);
    tick_n(2);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check("merge_en_after_done", v_merge_en, 1);
  endtask

  task automatic split_round();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (v_split_start) seen = 1'b1;
    end
    check("split_start_seen", seen, 1);
    tick_n(3);
    split_done = 1'b1;
    tick();
    split_done = 1'b0;
    check("code_valid_after_split", v_code_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    gray_valid = 1'b0; sort_done = 1'b0; split_done = 1'b0;
    sel3 = 1'b0; reset6 = 1'b0; reset3 = 1'b0;

    // Reset state.
    apply_reset();
    check_reset_vals("reset");

    // Nominal run: 100 symbols, rounds 6..2, split.
    snap();
    feed(100);
    check("nominal_sym_cnt", v_sym_cnt, 100);
    for (int k = 0; k < 5; k++) sort_round(3'(6 - k));
    split_round();
    check("nominal_round", v_round, 5);
    check("nominal_err", v_err, 0);
    check("nominal_cnt_valid_pulses", n_cnt - s_cnt, 1);
    check("nominal_sort_start_pulses", n_ss - s_ss, 5);
    check("nominal_merge_pulses", n_me - s_me, 5);
    check("nominal_split_pulses", n_sp - s_sp, 1);

    // Stray inputs while in DONE.
    snap();
    gray_valid = 1'b1; sort_done = 1'b1; split_done = 1'b1;
    tick_n(3);
    gray_valid = 1'b0; sort_done = 1'b0; split_done = 1'b0;
    tick_n(3);
    check("done_code_valid_held", v_code_valid, 1);
    check("done_sym_cnt_held", v_sym_cnt, 100);
    check("done_no_pulses", (n_cnt - s_cnt) + (n_ss - s_ss) + (n_me - s_me) + (n_sp - s_sp), 0);

    // Watchdog: second sort round never completes.
    apply_reset();
    feed(5);
    sort_round(3'd6);
    wait_sort_start();
    check("wdog_sort_num", v_sort_num, 5);
    lat = 0;
    for (int i = 1; i <= 100 && lat == 0; i++) begin
      tick();
      if (v_err) lat = i;
    end
    check("wdog_latency", lat, 63);
    check("wdog_round", v_round, 1);
    check("wdog_code_valid", v_code_valid, 0);
    snap();
    sort_done = 1'b1; tick(); sort_done = 1'b0;
    split_done = 1'b1; tick(); split_done = 1'b0;
    tick_n(10);
    check("err_held", v_err, 1);
    check("err_no_pulses", (n_cnt - s_cnt) + (n_ss - s_ss) + (n_me - s_me) + (n_sp - s_sp), 0);
    check("err_round_held", v_round, 1);

    // Saturation, then a sort_done glitch during SORT_REQ.
    apply_reset();
    feed(200);
    check("sat_sym_cnt", v_sym_cnt, 127);
    tick();
    check("sat_cnt_valid", v_cnt_valid, 1);
    snap();
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check("glitch_sort_start", v_sort_start, 1);
    tick_n(5);
    check("glitch_no_merge", n_me - s_me, 0);
    check("glitch_round", v_round, 0);
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    check("glitch_late_merge", v_merge_en, 1);
    check("glitch_late_round", v_round, 1);

    // Mid-run reset during the third SORT_WAIT, asserted between edges.
    apply_reset();
    feed(10);
    sort_round(3'd6);
    sort_round(3'd5);
    wait_sort_start();
    check("midrst_sort_num", v_sort_num, 4);
    tick();
    #2 reset6 = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    reset6 = 1'b1;
    tick();
    feed(7);
    for (int k = 0; k < 5; k++) sort_round(3'(6 - k));
    split_round();
    check("rerun_sym_cnt", v_sym_cnt, 7);
    check("rerun_round", v_round, 5);
    check("rerun_err", v_err, 0);

    // NUM_SYM = 3 instance.
    sel3 = 1'b1;
    apply_reset();
    check_reset_vals("n3_reset");
    snap();
    feed(4);
    sort_round(3'd3);
    sort_round(3'd2);
    split_round();
    check("n3_round", v_round, 2);
    check("n3_sym_cnt", v_sym_cnt, 4);
    check("n3_sort_start_pulses", n_ss - s_ss, 2);
    check("n3_merge_pulses", n_me - s_me, 2);
    check("n3_split_pulses", n_sp - s_sp, 1);

    check("pulse_mutual_exclusion", mutex_err, 0);
    check("sort_num_stable_to_merge", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_ctrl.md
HUFFMAN_CTRL -- requirements
Module: huffman_ctrl

Interface
REQ-001 Parameter: WDOG_W, default 6; watchdog counter width; timeout limit = 2^WDOG_W-1 cycles.
REQ-002 Parameter: NUM_SYM, default 6; initial symbol count for the first sort round; legal range 2..6.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-005 gray_valid  input  1  symbol stream valid; high for the duration of one frame.
REQ-006 sort_done  input  1  sort engine completion, one-cycle pulse.
REQ-007 split_done  input  1  code-split engine completion, one-cycle pulse.
REQ-008 CNT_valid  output  1  counting complete, one-cycle pulse to sort engine.
REQ-009 sort_start  output  1  sort round request, one-cycle pulse.
REQ-010 sort_num  output  3  active item count for the current sort round.
REQ-011 merge_en  output  1  merge the two lowest-probability items, one-cycle pulse.
REQ-012 round  output  3  completed merge count, 0..NUM_SYM-1.
REQ-013 split_start  output  1  start code-split phase, one-cycle pulse.
REQ-014 code_valid  output  1  Huffman codes final, level.
REQ-015 err  output  1  watchdog timeout, level.
REQ-016 sym_cnt  output  7  number of gray_valid cycles in the frame, saturating at 127.

Function
REQ-017 The FSM SHALL have the states IDLE, COUNT, SORT_REQ, SORT_WAIT, MERGE, SPLIT_REQ, SPLIT_WAIT, DONE and ERR; all outputs SHALL be registered.
REQ-018 IDLE: gray_valid=1 -> COUNT, with sym_cnt<=1.
REQ-019 COUNT: gray_valid=1 -> sym_cnt+1, saturating at 127; gray_valid=0 -> SORT_REQ, with CNT_valid=1 for exactly the next cycle.
REQ-020 SORT_REQ: sort_start=1 for one cycle -> SORT_WAIT; watchdog cleared; sort_done sampled in SORT_REQ SHALL be ignored.
REQ-021 sort_num SHALL be stable from sort_start until the MERGE exit.
REQ-022 SORT_WAIT: sort_done=1 -> MERGE; otherwise watchdog+1; watchdog reaching 2^WDOG_W-1 -> ERR.
REQ-023 MERGE: merge_en=1 for one cycle and round+1.
REQ-024 MERGE exit: sort_num==2 -> SPLIT_REQ; otherwise sort_num-1 -> SORT_REQ.
REQ-025 Sort rounds: for NUM_SYM=6 the block SHALL issue exactly 5 sort_start pulses, with sort_num 6,5,4,3,2.
REQ-026 Spacing: sort_start pulses SHALL be separated by at least 2 cycles after the preceding merge_en.
REQ-027 SPLIT_REQ: split_start=1 for one cycle -> SPLIT_WAIT; watchdog cleared.
REQ-028 SPLIT_WAIT: split_done=1 -> DONE; watchdog timeout -> ERR, as in REQ-022.
REQ-029 DONE: code_valid=1, held until reset; all inputs ignored.
REQ-030 ERR: err=1, held until reset; no further pulses; code_valid=0.
REQ-031 gray_valid outside IDLE/COUNT SHALL be ignored.
REQ-032 sort_done outside SORT_WAIT and split_done outside SPLIT_WAIT SHALL be ignored.
REQ-033 At most one of CNT_valid, sort_start, merge_en, split_start SHALL be high in any cycle.

Reset
REQ-034 reset=0 SHALL immediately (asynchronously) force IDLE, and the outputs CNT_valid=0, sort_start=0, merge_en=0, split_start=0, code_valid=0, err=0, round=0, sym_cnt=0, sort_num=NUM_SYM; the watchdog SHALL clear.
REQ-035 Reset asserted mid-operation SHALL abort the run; pulses drop in the same cycle; operation resumes only from IDLE after reset=1.

Verification
REQ-036 Nominal run: gray_valid high 100 cycles, then low; sort_done 3 cycles after each sort_start; split_done 4 cycles after split_start -> sym_cnt=100, one CNT_valid, sort_num sequence 6,5,4,3,2, 5 merge_en pulses, round=5, code_valid=1, err=0.
REQ-037 Watchdog: sort_done withheld after the 2nd sort_start -> err=1 exactly 63 cycles after entering SORT_WAIT, round=1, no further pulses.
REQ-038 Saturation and glitch: gray_valid high 200 cycles -> sym_cnt=127; a spurious sort_done in the SORT_REQ cycle -> no MERGE until a later sort_done.
REQ-039 Mid-run reset: reset=0 during the 3rd SORT_WAIT -> all outputs at reset values in the same cycle; a rerun after release completes normally.
REQ-040 Parameter: NUM_SYM=3 -> 2 sort rounds (sort_num 3,2), then split_start; code_valid=1 after split_done.
REQ-041 Stray input: gray_valid pulse while in DONE -> code_valid stays 1; sym_cnt unchanged.
